// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner: counter sizing for the
// debounce stage.
package input_conditioner_pkg;

  // Synchronizer stages that are always present ahead of any extra depth.
  localparam int unsigned BASE_DEPTH = 2;

  // Counter width for a debounce threshold n; never zero so bypass builds stay legal.
  function automatic int unsigned cnt_width(int unsigned n);
    int unsigned w;
    if (n == 0) begin
      w = 1;
    end else begin
      w = $clog2(n + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned channel: multi-flop synchronizer, optional debounce counter,
// and edge pulses derived from the conditioned level.
module input_conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned EXTRA_DEPTH     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic bit_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned DEPTH = BASE_DEPTH + EXTRA_DEPTH;
  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [DEPTH-1:0] sync_q;
  logic             s;
  logic             prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], bit_in};
    end
  end

  assign s = sync_q[DEPTH-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign bit_out = s;
  end else begin : g_debounce
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Any cycle where s agrees with the output restarts the stability window.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_d = s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= RESET_VALUE;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    assign bit_out = level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= bit_out;
    end
  end

  assign rise = bit_out & ~prev_q;
  assign fall = ~bit_out & prev_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: WIDTH independent synchronize/debounce/edge
// channels sharing only clock and reset.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned          WIDTH           = 1,
  parameter int unsigned          EXTRA_DEPTH     = 0,
  parameter int unsigned          DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0]     RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bit_in,
  output logic [WIDTH-1:0] bit_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    input_conditioner_channel #(
      .EXTRA_DEPTH     (EXTRA_DEPTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .bit_in  (bit_in[i]),
      .bit_out (bit_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter WIDTH, default 1: number of independent channels, 1..32.
REQ-002 Parameter EXTRA_DEPTH, default 0: flops added beyond the two-flop synchronizer; DEPTH = 2 + EXTRA_DEPTH.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0: consecutive stable cycles required before an output change; 0 = debounce bypassed; legal range 0..65535.
REQ-004 Parameter RESET_VALUE, default all zeros, WIDTH bits: per-channel reset/initial level.
REQ-005 Port clk  input  1  sole clock; all state on posedge clk.
REQ-006 Port rst_n  input  1  reset; synchronous and active-low.
REQ-007 Port bit_in  input  WIDTH  asynchronous raw inputs, one bit per channel.
REQ-008 Port bit_out  output  WIDTH  synchronized, debounced level per channel.
REQ-009 Port rise  output  WIDTH  one-cycle pulse per channel on a 0->1 change of bit_out.
REQ-010 Port fall  output  WIDTH  one-cycle pulse per channel on a 1->0 change of bit_out.

Function
REQ-011 Each channel SHALL be fully independent; no logic is shared across channels except clk and rst_n.
REQ-012 Each channel SHALL shift bit_in through a DEPTH-stage flop chain every clk edge; the last stage is the synchronized level s.
REQ-013 With DEBOUNCE_CYCLES = 0, bit_out SHALL equal s with no extra flop; latency is DEPTH edges.
REQ-014 With DEBOUNCE_CYCLES = N >= 1, each channel SHALL hold a counter of width clog2(N+1).
REQ-015 Debounce: if s == bit_out, the counter SHALL clear to 0.
REQ-016 Debounce: if s != bit_out and counter < N-1, the counter SHALL increment.
REQ-017 Debounce: if s != bit_out and counter == N-1, bit_out SHALL take s and the counter SHALL clear on the same edge.
REQ-018 A clean step on bit_in SHALL therefore appear on bit_out exactly DEPTH + N edges after first capture.
REQ-019 A pulse on s shorter than N cycles SHALL NOT change bit_out and SHALL NOT generate rise or fall.
REQ-020 The counter SHALL never exceed N-1 and SHALL never wrap.
REQ-021 rise/fall SHALL be registered against a previous-bit_out flop: rise = bit_out & ~prev, fall = ~bit_out & prev, each high exactly one cycle, coincident with the first cycle bit_out shows the new level.
REQ-022 rise and fall of one channel SHALL never be high together.

Reset
REQ-023 While rst_n is low at a clk edge, every synchronizer stage, bit_out and prev SHALL load RESET_VALUE and every counter SHALL load 0.
REQ-024 rise and fall SHALL be 0 during reset and on the first cycle after release.
REQ-025 Reset asserted mid-count SHALL discard the partial count; after release a change needs the full DEPTH + N edges again.
REQ-026 Initial (power-up) values SHALL equal the reset values.

Structure
REQ-027 No shared package is required; DEPTH and counter width SHALL be local constants.
REQ-028 Per-channel logic SHALL live in one sub-module, input_conditioner_channel, instantiated WIDTH times in a generate loop.
REQ-029 With WIDTH=1, EXTRA_DEPTH=E, DEBOUNCE_CYCLES=0, RESET_VALUE=0, bit_out SHALL be cycle-identical to the existing single-bit synchronizer with the same EXTRA_DEPTH.

Verification (WIDTH=4, EXTRA_DEPTH=0, DEBOUNCE_CYCLES=3, RESET_VALUE=4'b0000 unless stated)
REQ-030 Reset: bit_in=4'hF, rst_n low 2 edges -> bit_out=4'h0, rise=fall=0 during reset and on the first cycle after release.
REQ-031 Step: bit_in[0] 0->1 held -> bit_out[0]=1 exactly 5 edges after capture; rise[0] high 1 cycle; other channels unchanged.
REQ-032 Glitch: bit_in[1] high 2 cycles then low -> bit_out[1] stays 0; no rise/fall on any channel.
REQ-033 Reset mid-count: bit_in[2] high, rst_n low after edge 4 -> bit_out[2] stays 0; after release bit_out[2]=1 exactly 5 edges later.
REQ-034 Simultaneous: bit_in[0] 1->0 and bit_in[3] 0->1 same cycle -> fall[0] and rise[3] pulse on the same cycle, 5 edges after capture.
REQ-035 Bypass: DEBOUNCE_CYCLES=0, RESET_VALUE=4'hA -> bit_out=4'hA after reset; step bit_in[0] 0->1 -> bit_out[0]=1 after 2 edges, rise[0] one cycle.
